// File: rtl/pulse_statistic_pkg.sv
// Shared types and constants for the pulse classifier and its rate divider.
package pulse_statistic_pkg;
   localparam int CNT_W   = 16;
   localparam int RATE_W  = 8;
   localparam int NUM_W   = 23;
   localparam int PERCENT = 100;
   localparam int N_CLASS = 4;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_OPEN_WAIT = 2'd1,
      ST_DISCHARGE = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      CLS_NORMAL = 2'd0,
      CLS_ARC    = 2'd1,
      CLS_OPEN   = 2'd2,
      CLS_SHORT  = 2'd3
   } class_t;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
   endfunction
endpackage

// File: rtl/pulse_rate_divider.sv
// Sequential unsigned divider returning floor(num/den) for a quotient known to be <= 100.
module pulse_rate_divider
   import pulse_statistic_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              start_i,
   input  logic [NUM_W-1:0]  num_i,
   input  logic [CNT_W-1:0]  den_i,
   output logic              done_o,
   output logic [RATE_W-1:0] quot_o
);
   logic              busy_q;
   logic              done_q;
   logic [2:0]        step_q;
   logic [NUM_W-1:0]  rem_q, rem_d;
   logic [CNT_W-1:0]  den_q;
   logic [RATE_W-2:0] quot_q, quot_d;
   logic [NUM_W-1:0]  trial;

   // count <= total keeps the quotient under 128, so only seven restoring steps are needed.
   always_comb begin
      trial  = NUM_W'(den_q) << step_q;
      rem_d  = rem_q;
      quot_d = quot_q;
      if (rem_q >= trial) begin
         rem_d  = rem_q - trial;
         quot_d = quot_q | ((RATE_W-1)'(1) << step_q);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         busy_q <= 1'b0;
         done_q <= 1'b0;
         step_q <= '0;
         rem_q  <= '0;
         den_q  <= '0;
         quot_q <= '0;
      end else begin
         done_q <= 1'b0;
         if (start_i && !busy_q) begin
            busy_q <= 1'b1;
            step_q <= 3'd6;
            rem_q  <= num_i;
            den_q  <= den_i;
            quot_q <= '0;
         end else if (busy_q) begin
            rem_q  <= rem_d;
            quot_q <= quot_d;
            if (step_q == 3'd0) begin
               busy_q <= 1'b0;
               done_q <= 1'b1;
            end else begin
               step_q <= step_q - 3'd1;
            end
         end
      end
   end

   assign done_o = done_q;
   assign quot_o = (den_q == '0) ? '0 : {1'b0, quot_q};
endmodule

// File: rtl/pulse_statistic.sv
// EDM gap pulse classifier with per-window class percentages.
// Optional output total_pulse_count is enabled by defining PULSE_STATISTIC_COUNT_EN.
module pulse_statistic
   import pulse_statistic_pkg::*;
#(
   parameter logic signed [15:0] V_OPEN                 = 16'sd60,
   parameter logic signed [15:0] V_SHORT                = 16'sd5,
   parameter logic signed [15:0] I_DISCHARGE            = 16'sd10,
   parameter logic [CNT_W-1:0]   NORMAL_DISCHARGE_DELAY = 16'd10
) (
   input  logic               clk,
   input  logic               rst,
   input  logic signed [15:0] sample_current,
   input  logic signed [15:0] sample_voltage,
   input  logic               is_machine,
   input  logic               feedback_finished,
   output logic [RATE_W-1:0]  normal_pulse_rate,
   output logic [RATE_W-1:0]  arc_pulse_rate,
   output logic [RATE_W-1:0]  open_pulse_rate,
   output logic [RATE_W-1:0]  short_pulse_rate
`ifdef PULSE_STATISTIC_COUNT_EN
   ,
   output logic [CNT_W-1:0]   total_pulse_count
`endif
);
   state_t           state_q, state_d;
   class_t           cls_q, cls_d, pulse_cls;
   logic [CNT_W-1:0] delay_q, delay_d;
   logic             pulse_done;
   logic             dis, opn, sht, interval;

   logic [CNT_W-1:0]  total_q, snap_total_q;
   logic [CNT_W-1:0]  snap_cnt [N_CLASS];
   logic [RATE_W-1:0] res_q  [N_CLASS];
   logic [RATE_W-1:0] rate_q [N_CLASS];
   logic              div_active_q, start_q;
   logic [1:0]        div_idx_q;
   logic              div_done;
   logic [RATE_W-1:0] div_quot;
   logic              strobe_accept, total_full;

   assign dis      = sample_current >= I_DISCHARGE;
   assign opn      = sample_voltage >= V_OPEN;
   assign sht      = sample_voltage < V_SHORT;
   assign interval = !dis && sht;

   always_comb begin
      state_d    = state_q;
      cls_d      = cls_q;
      delay_d    = delay_q;
      pulse_done = 1'b0;
      pulse_cls  = cls_q;
      if (!is_machine) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (dis) begin
                  state_d = ST_DISCHARGE;
                  cls_d   = sht ? CLS_SHORT : CLS_ARC;
               end else if (opn) begin
                  state_d = ST_OPEN_WAIT;
                  delay_d = CNT_W'(1);
               end
            end
            ST_OPEN_WAIT: begin
               if (dis) begin
                  state_d = ST_DISCHARGE;
                  if (sht)                                    cls_d = CLS_SHORT;
                  else if (delay_q >= NORMAL_DISCHARGE_DELAY) cls_d = CLS_NORMAL;
                  else                                        cls_d = CLS_ARC;
               end else if (interval) begin
                  state_d    = ST_IDLE;
                  pulse_done = 1'b1;
                  pulse_cls  = CLS_OPEN;
               end else begin
                  delay_d = sat_inc(delay_q);
               end
            end
            ST_DISCHARGE: begin
               if (interval) begin
                  state_d    = ST_IDLE;
                  pulse_done = 1'b1;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   assign strobe_accept = feedback_finished && !div_active_q;
   assign total_full    = (total_q == {CNT_W{1'b1}});

   // A pulse ending in the strobe cycle seeds the fresh window.
   genvar gi;
   for (gi = 0; gi < N_CLASS; gi++) begin : g_class
      logic [CNT_W-1:0] cnt_q, snap_q;
      logic             hit;
      assign hit          = pulse_done && (pulse_cls == class_t'(gi));
      assign snap_cnt[gi] = snap_q;
      always_ff @(posedge clk) begin
         if (rst) begin
            cnt_q  <= '0;
            snap_q <= '0;
         end else if (strobe_accept) begin
            snap_q <= cnt_q;
            cnt_q  <= hit ? CNT_W'(1) : '0;
         end else if (hit && !total_full) begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

   pulse_rate_divider u_div (
      .clk     (clk),
      .rst     (rst),
      .start_i (start_q),
      .num_i   (NUM_W'(snap_cnt[div_idx_q]) * NUM_W'(PERCENT)),
      .den_i   (snap_total_q),
      .done_o  (div_done),
      .quot_o  (div_quot)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         cls_q        <= CLS_NORMAL;
         delay_q      <= '0;
         total_q      <= '0;
         snap_total_q <= '0;
         div_active_q <= 1'b0;
         start_q      <= 1'b0;
         div_idx_q    <= '0;
         for (int k = 0; k < N_CLASS; k++) begin
            res_q[k]  <= '0;
            rate_q[k] <= '0;
         end
      end else begin
         state_q <= state_d;
         cls_q   <= cls_d;
         delay_q <= delay_d;
         start_q <= 1'b0;
         if (strobe_accept) begin
            snap_total_q <= total_q;
            total_q      <= pulse_done ? CNT_W'(1) : '0;
            div_active_q <= 1'b1;
            div_idx_q    <= '0;
            start_q      <= 1'b1;
         end else if (pulse_done && !total_full) begin
            total_q <= total_q + 1'b1;
         end
         if (div_done) begin
            if (div_idx_q == 2'd3) begin
               for (int k = 0; k < N_CLASS - 1; k++) rate_q[k] <= res_q[k];
               rate_q[N_CLASS-1] <= div_quot;
               div_active_q      <= 1'b0;
            end else begin
               res_q[div_idx_q] <= div_quot;
               div_idx_q        <= div_idx_q + 2'd1;
               start_q          <= 1'b1;
            end
         end
      end
   end

   assign normal_pulse_rate = rate_q[CLS_NORMAL];
   assign arc_pulse_rate    = rate_q[CLS_ARC];
   assign open_pulse_rate   = rate_q[CLS_OPEN];
   assign short_pulse_rate  = rate_q[CLS_SHORT];

`ifdef PULSE_STATISTIC_COUNT_EN
   logic [CNT_W-1:0] total_cnt_q;
   always_ff @(posedge clk) begin
      if (rst)                                total_cnt_q <= '0;
      else if (div_done && div_idx_q == 2'd3) total_cnt_q <= snap_total_q;
   end
   assign total_pulse_count = total_cnt_q;
`endif
endmodule

// File: tb/tb_pulse_statistic.sv
// Randomized bench: pulses are generated at scenario level and classified by a rule-based model.
module tb_pulse_statistic;
   logic               clk = 1'b0;
   logic               rst;
   logic signed [15:0] sample_current, sample_voltage;
   logic               is_machine, feedback_finished;
   logic [7:0]         normal_pulse_rate, arc_pulse_rate, open_pulse_rate, short_pulse_rate;
`ifdef PULSE_STATISTIC_COUNT_EN
   logic [15:0]        total_pulse_count;
`endif

   always #5 clk = ~clk;

   pulse_statistic dut (
      .clk               (clk),
      .rst               (rst),
      .sample_current    (sample_current),
      .sample_voltage    (sample_voltage),
      .is_machine        (is_machine),
      .feedback_finished (feedback_finished),
      .normal_pulse_rate (normal_pulse_rate),
      .arc_pulse_rate    (arc_pulse_rate),
      .open_pulse_rate   (open_pulse_rate),
      .short_pulse_rate  (short_pulse_rate)
`ifdef PULSE_STATISTIC_COUNT_EN
      ,
      .total_pulse_count (total_pulse_count)
`endif
   );

   int n_cmp = 0;
   int n_bad = 0;
   int mcnt[4];   // model counts: 0 normal, 1 arc, 2 open, 3 short

   function automatic logic [31:0] rates_now();
      return {normal_pulse_rate, arc_pulse_rate, open_pulse_rate, short_pulse_rate};
   endfunction

   function automatic int model_total();
      return mcnt[0] + mcnt[1] + mcnt[2] + mcnt[3];
   endfunction

   function automatic logic [31:0] model_rates();
      int tot = model_total();
      logic [31:0] r = '0;
      if (tot != 0)
         for (int k = 0; k < 4; k++) r[31-8*k -: 8] = 8'(mcnt[k] * 100 / tot);
      return r;
   endfunction

   function automatic int classify(input int n_open, input int dv);
      if (dv < 5)        return 3;
      if (n_open >= 10)  return 0;
      return 1;
   endfunction

   task automatic cyc(input int v, input int i);
      sample_voltage = 16'(v);
      sample_current = 16'(i);
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) cyc($urandom_range(0, 4), $urandom_range(0, 9));
   endtask

   task automatic pulse_dis(input int n_open, input int dv, input int d_len, input int ov);
      for (int c = 0; c < n_open; c++) cyc(ov, $urandom_range(0, 9));
      for (int c = 0; c < d_len; c++) cyc(dv, 10 + $urandom_range(0, 40));
      cyc(0, 0);
      mcnt[classify(n_open, dv)]++;
   endtask

   task automatic pulse_open(input int n_open, input int ov);
      for (int c = 0; c < n_open; c++) cyc(ov, $urandom_range(0, 9));
      cyc(0, 0);
      mcnt[2]++;
   endtask

   task automatic model_clear();
      for (int k = 0; k < 4; k++) mcnt[k] = 0;
   endtask

   task automatic close_window(input string tag);
      logic [31:0] exp_r, old_r, got;
      int          tot;
      bit          changed = 0;
      exp_r = model_rates();
      tot   = model_total();
      old_r = rates_now();
      model_clear();
      feedback_finished = 1'b1;
      cyc(0, 0);
      feedback_finished = 1'b0;
      for (int c = 1; c <= 72; c++) begin
         cyc(0, 0);
         got = rates_now();
         if (!changed && got != old_r) begin
            changed = 1;
            n_cmp++;
            if (got !== exp_r) begin
               n_bad++;
               $display("FAIL %s_first_update: got %h required %h at cycle %0d", tag, got, exp_r, c);
            end
         end
      end
      got = rates_now();
      n_cmp++;
      if (got !== exp_r) begin
         n_bad++;
         $display("FAIL %s_rates: got %h required %h", tag, got, exp_r);
      end
`ifdef PULSE_STATISTIC_COUNT_EN
      n_cmp++;
      if (total_pulse_count !== 16'(tot)) begin
         n_bad++;
         $display("FAIL %s_total: got %0d required %0d", tag, total_pulse_count, tot);
      end
`endif
      $display("window %s: pulses=%0d rates N/A/O/S=%0d/%0d/%0d/%0d", tag, tot,
               got[31:24], got[23:16], got[15:8], got[7:0]);
   endtask

   task automatic test_reset();
      rst = 1'b1; is_machine = 1'b1; feedback_finished = 1'b0;
      repeat (3) cyc(0, 0);
      rst = 1'b0;
      model_clear();
      n_cmp++;
      if (rates_now() !== 32'h0) begin
         n_bad++;
         $display("FAIL reset_rates: got %h required 00000000", rates_now());
      end
   endtask

   task automatic test_classes();
      idle(2);
      pulse_dis(10000, 25, 1, 120);
      close_window("normal");
      pulse_dis(0, 20, 1, 120);
      close_window("arc_direct");
      pulse_dis(5, 25, 2, 120);
      close_window("arc_early");
      pulse_open(6, 120);
      close_window("open");
      pulse_dis(0, 3, 2, 120);
      close_window("short");
   endtask

   task automatic test_mix_and_boundary();
      pulse_dis(12, 30, 2, 120);
      pulse_dis(0, 40, 1, 120);
      pulse_open(4, 200);
      pulse_dis(3, 1, 1, 120);
      close_window("mix");
      pulse_dis(10, 5, 1, 60);   // exact thresholds: V=60 opens, delay 10 is normal, V=5 not short
      pulse_dis(9, 5, 1, 60);
      pulse_dis(0, 4, 1, 60);
      close_window("boundary");
      close_window("empty");
   endtask

   task automatic test_machine_off();
      for (int c = 0; c < 4; c++) cyc(120, 2);
      cyc(25, 30);
      is_machine = 1'b0;
      cyc(25, 30);
      is_machine = 1'b1;
      cyc(0, 0);
      pulse_open(3, 90);
      close_window("machine_off");
   endtask

   task automatic test_busy_strobe();
      logic [31:0] exp_a;
      pulse_dis(12, 25, 1, 120);
      exp_a = model_rates();
      model_clear();
      feedback_finished = 1'b1; cyc(0, 0); feedback_finished = 1'b0;
      idle(3);
      pulse_dis(0, 2, 1, 120);
      feedback_finished = 1'b1; cyc(0, 0); feedback_finished = 1'b0;
      repeat (70) cyc(0, 0);
      n_cmp++;
      if (rates_now() !== exp_a) begin
         n_bad++;
         $display("FAIL busy_first_window: got %h required %h", rates_now(), exp_a);
      end
      close_window("after_busy");
   endtask

   task automatic test_reset_mid();
      pulse_dis(0, 30, 2, 120);
      repeat (3) cyc(120, 3);
      rst = 1'b1; repeat (2) cyc(0, 0); rst = 1'b0;
      model_clear();
      n_cmp++;
      if (rates_now() !== 32'h0) begin
         n_bad++;
         $display("FAIL reset_mid_window: got %h required 00000000", rates_now());
      end
      pulse_dis(0, 30, 1, 120);
      feedback_finished = 1'b1; cyc(0, 0); feedback_finished = 1'b0;
      repeat (5) cyc(0, 0);
      rst = 1'b1; repeat (2) cyc(0, 0); rst = 1'b0;
      model_clear();
      repeat (80) cyc(0, 0);
      n_cmp++;
      if (rates_now() !== 32'h0) begin
         n_bad++;
         $display("FAIL reset_mid_division: got %h required 00000000", rates_now());
      end
      pulse_open(3, 120);
      close_window("post_reset");
   endtask

   task automatic test_random();
      for (int w = 0; w < 4; w++) begin
         int n = $urandom_range(3, 12);
         for (int p = 0; p < n; p++) begin
            int ov = 60 + $urandom_range(0, 500);
            case ($urandom_range(0, 3))
               0: pulse_dis($urandom_range(10, 30), $urandom_range(5, 59), $urandom_range(1, 4), ov);
               1: pulse_dis($urandom_range(0, 9), $urandom_range(5, 59), $urandom_range(1, 4), ov);
               2: pulse_open($urandom_range(1, 20), ov);
               default: pulse_dis($urandom_range(0, 15), $urandom_range(0, 4), $urandom_range(1, 3), ov);
            endcase
            idle($urandom_range(0, 3));
         end
         close_window($sformatf("random%0d", w));
      end
   endtask

   initial begin
      sample_current = '0;
      sample_voltage = '0;
      model_clear();
      test_reset();
      test_classes();
      test_mix_and_boundary();
      test_machine_off();
      test_busy_strobe();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
